lsu_dmem_master: RTL

- Load/store unit between the CPU execute stage and the word-organised data memory.
- Converts MIPS byte-addressed lw/lh/lhu/lb/lbu/sw/sh/sb requests into word accesses on the memory's single-port interface:
  - 11-bit word address, 32-bit write data, write enable, combinational read data.
  - The memory commits writes on the falling clock edge.
- Sub-word stores are done as read-modify-write sequences.
- Sub-word loads are extracted and sign- or zero-extended.
- Misaligned and out-of-range accesses are flagged instead of reaching memory.

---
 rtl/lsu_pkg.sv | 34 +++
 rtl/lsu_lane.sv | 54 +++++
 rtl/lsu_dmem_master.sv | 131 +++++++++++++
 3 files changed

// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: op codes, FSM states,
// default memory placement and the access-legality helper.
package lsu_pkg;

    localparam logic [31:0] BASE_ADDR_DEF = 32'h1001_0000;
    localparam int          MEM_AW_DEF    = 11;

    typedef enum logic [2:0] {
        OP_LW  = 3'd0,
        OP_LH  = 3'd1,
        OP_LHU = 3'd2,
        OP_LB  = 3'd3,
        OP_LBU = 3'd4,
        OP_SW  = 3'd5,
        OP_SH  = 3'd6,
        OP_SB  = 3'd7
    } lsu_op_e;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_MERGE  = 2'd2,
        ST_RESP   = 2'd3
    } lsu_state_e;

    function automatic logic is_misaligned(input lsu_op_e op, input logic [1:0] lo);
        case (op)
            OP_LW, OP_SW:         return (lo != 2'd0);
            OP_LH, OP_LHU, OP_SH: return lo[0];
            default:              return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/lsu_lane.sv
// Byte/halfword lane logic: extracts and extends load data and
// splices store data into a word for read-modify-write.
module lsu_lane
    import lsu_pkg::*;
(
    input  logic [31:0] word_i,
    input  logic [1:0]  bsel_i,
    input  lsu_op_e     op_i,
    input  logic [15:0] sdata_i,
    output logic [31:0] load_o,
    output logic [31:0] merge_o
);

    logic [7:0]  byte_s;
    logic [15:0] half_s;

    // Lane selection, load extension and store merge
    always_comb begin
        case (bsel_i)
            2'd0:    byte_s = word_i[7:0];
            2'd1:    byte_s = word_i[15:8];
            2'd2:    byte_s = word_i[23:16];
            default: byte_s = word_i[31:24];
        endcase
        half_s = bsel_i[1] ? word_i[31:16] : word_i[15:0];

        case (op_i)
            OP_LB:   load_o = {{24{byte_s[7]}}, byte_s};
            OP_LBU:  load_o = {24'd0, byte_s};
            OP_LH:   load_o = {{16{half_s[15]}}, half_s};
            OP_LHU:  load_o = {16'd0, half_s};
            default: load_o = word_i;
        endcase

        merge_o = word_i;
        if (op_i == OP_SH) begin
            if (bsel_i[1]) begin
                merge_o[31:16] = sdata_i;
            end else begin
                merge_o[15:0] = sdata_i;
            end
        end else if (op_i == OP_SB) begin
            case (bsel_i)
                2'd0:    merge_o[7:0]   = sdata_i[7:0];
                2'd1:    merge_o[15:8]  = sdata_i[7:0];
                2'd2:    merge_o[23:16] = sdata_i[7:0];
                default: merge_o[31:24] = sdata_i[7:0];
            endcase
        end else begin
            merge_o = word_i;
        end
    end

endmodule

// File: rtl/lsu_dmem_master.sv
// Load/store unit driving a word-organised single-port data memory;
// sub-word stores are read-modify-write, illegal accesses never reach memory.
module lsu_dmem_master
    import lsu_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = BASE_ADDR_DEF,
    parameter int          MEM_AW    = MEM_AW_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req,
    input  logic [2:0]        op,
    input  logic [31:0]       addr,
    input  logic [31:0]       wdata,
    output logic              busy,
    output logic              done,
    output logic [31:0]       rdata,
    output logic              err,
    output logic [MEM_AW-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              mem_we,
    input  logic [31:0]       mem_rdata
);

    lsu_state_e        state_q, state_d;
    lsu_op_e           op_q, op_d;
    logic [1:0]        bsel_q, bsel_d;
    logic [MEM_AW-1:0] idx_q, idx_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [31:0]       merge_q, merge_d;
    logic [31:0]       rdata_q, rdata_d;
    logic              err_q, err_d;

    // Word offset from the base; any bit above the index means out of range,
    // including addresses below the base that wrap to large values.
    logic [29:0] off_w_s;
    logic        illegal_s;
    logic [31:0] word_s, load_s, merged_s;

    assign off_w_s   = addr[31:2] - BASE_ADDR[31:2];
    assign illegal_s = (|off_w_s[29:MEM_AW]) | is_misaligned(lsu_op_e'(op), addr[1:0]);
    assign word_s    = (state_q == ST_MERGE) ? merge_q : mem_rdata;

    lsu_lane u_lane (
        .word_i  (word_s),
        .bsel_i  (bsel_q),
        .op_i    (op_q),
        .sdata_i (wdata_q[15:0]),
        .load_o  (load_s),
        .merge_o (merged_s)
    );

    assign busy     = (state_q != ST_IDLE);
    assign done     = (state_q == ST_RESP);
    assign rdata    = rdata_q;
    assign err      = err_q;
    assign mem_addr = idx_q;

    // Next-state and memory-strobe decode; mem_we depends on registered state only
    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        bsel_d    = bsel_q;
        idx_d     = idx_q;
        wdata_d   = wdata_q;
        merge_d   = merge_q;
        rdata_d   = rdata_q;
        err_d     = err_q;
        mem_we    = 1'b0;
        mem_wdata = 32'd0;
        case (state_q)
            ST_IDLE: begin
                if (req) begin
                    op_d    = lsu_op_e'(op);
                    bsel_d  = addr[1:0];
                    idx_d   = off_w_s[MEM_AW-1:0];
                    wdata_d = wdata;
                    rdata_d = 32'd0;
                    err_d   = illegal_s;
                    state_d = illegal_s ? ST_RESP : ST_ACCESS;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ACCESS: begin
                if (op_q == OP_SW) begin
                    mem_we    = 1'b1;
                    mem_wdata = wdata_q;
                    state_d   = ST_RESP;
                end else if ((op_q == OP_SH) || (op_q == OP_SB)) begin
                    merge_d = mem_rdata;
                    state_d = ST_MERGE;
                end else begin
                    rdata_d = load_s;
                    state_d = ST_RESP;
                end
            end
            ST_MERGE: begin
                mem_we    = 1'b1;
                mem_wdata = merged_s;
                state_d   = ST_RESP;
            end
            ST_RESP: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // State and datapath registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            op_q    <= OP_LW;
            bsel_q  <= 2'd0;
            idx_q   <= '0;
            wdata_q <= 32'd0;
            merge_q <= 32'd0;
            rdata_q <= 32'd0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            bsel_q  <= bsel_d;
            idx_q   <= idx_d;
            wdata_q <= wdata_d;
            merge_q <= merge_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

endmodule
